// File: rtl/tx_framer_if.sv
// Byte-stream ingress bundle for tx_framer: payload byte, last flag and the
// valid/ready handshake. The producer drives the master side and the framer
// sits on the slave side.
interface tx_framer_if;
  logic [7:0] s_data_i;
  logic       s_valid_i;
  logic       s_last_i;
  logic       s_ready_o;

  modport master (output s_data_i, output s_valid_i, output s_last_i,
                  input  s_ready_o);
  modport slave  (input  s_data_i, input  s_valid_i, input  s_last_i,
                  output s_ready_o);
endinterface

// File: rtl/tx_framer.sv
// tx_framer: buffers {last, byte} entries in a small FIFO and frames them
// into a 9-bit symbol stream (K flag + byte) for an 8b10b serializer.
// Each packet goes out as SOF, data..., EOF; COMMA fills the idle gaps, and
// FILL is inserted (with an underrun pulse) when the FIFO runs dry mid-packet.
module tx_framer #(
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  tx_framer_if.slave                 s,
  output logic [8:0]                 sym_o,
  input  logic                       sym_req_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       underrun_o,
  output logic [15:0]                pkt_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  localparam logic [8:0] SYM_COMMA = 9'h1BC;
  localparam logic [8:0] SYM_SOF   = 9'h1FB;
  localparam logic [8:0] SYM_EOF   = 9'h1FD;
  localparam logic [8:0] SYM_FILL  = 9'h11C;

  // The state names the symbol currently presented on sym_o.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SOF  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_FILL = 3'd3;
  localparam logic [2:0] ST_EOF  = 3'd4;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [2:0]    state_q, state_d;
  logic [8:0]    sym_q, sym_d;
  logic          last_q, last_d;
  logic          underrun_q, underrun_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;

  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [8:0]    head;

  // Ready depends only on the registered level, never on a same-cycle pop.
  assign s.s_ready_o = (level_q < FULL_LVL);
  assign push        = s.s_valid_i && s.s_ready_o && !rst_i;
  // Emptiness is judged on the pre-push level, so a byte arriving this cycle
  // is invisible to this cycle's pop decision.
  assign fifo_empty  = (level_q == '0);
  assign head        = mem[rd_ptr_q];

  // Framing decision: advance only on a serializer request.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d    = state_q;
    sym_d      = sym_q;
    last_d     = last_q;
    underrun_d = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    pop        = 1'b0;
    if (sym_req_i) begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_d = ST_SOF;
            sym_d   = SYM_SOF;
          end else begin
            sym_d   = SYM_COMMA;
          end
        end
        ST_EOF: begin
          state_d   = ST_IDLE;
          sym_d     = SYM_COMMA;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
        default: begin
          // SOF, FILL, or DATA: close the packet if the byte on the line was
          // its last, otherwise fetch the next byte or stall with FILL.
          if (state_q == ST_DATA && last_q) begin
            state_d = ST_EOF;
            sym_d   = SYM_EOF;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_DATA;
            sym_d   = {1'b0, head[7:0]};
            last_d  = head[8];
          end else begin
            state_d    = ST_FILL;
            sym_d      = SYM_FILL;
            underrun_d = 1'b1;
          end
        end
      endcase
    end
  end

  // FIFO pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array is deliberately not reset; validity is tracked
    // by the pointers and level, so clearing it would only add logic.
    if (push) mem[wr_ptr_q] <= {s.s_last_i, s.s_data_i};
  end

  // Control state registers with synchronous reset taking priority.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values regardless of statement order.
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= ST_IDLE;
      sym_q      <= SYM_COMMA;
      last_q     <= 1'b0;
      underrun_q <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      sym_q      <= sym_d;
      last_q     <= last_d;
      underrun_q <= underrun_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign sym_o      = sym_q;
  assign level_o    = level_q;
  assign underrun_o = underrun_q;
  assign pkt_cnt_o  = pkt_cnt_q;

endmodule
